// File: rtl/conv_window_pkg.sv
// rtl/conv_window_pkg.sv - shared window constants, FSM state type and element indexing for conv_window_3x3
package conv_window_pkg;

   localparam int WIN_K = 3;
   localparam int WIN_N = WIN_K * WIN_K;

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

   // Flat position of window element (r,c); r=0 is the oldest row, c=0 the oldest column
   function automatic int win_idx(input int r, input int c);
      return WIN_K * r + c;
   endfunction

endpackage

// File: rtl/line_delay.sv
// rtl/line_delay.sv - CE-gated shift register, DEPTH stages of WID bits, storage not reset
module line_delay #(
   parameter int WID   = 8,
   parameter int DEPTH = 16
) (
   input  logic           CLK,
   input  logic           ce,
   input  logic [WID-1:0] din,
   output logic [WID-1:0] dout
);

   logic [WID-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (ce) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_3x3.sv
// rtl/conv_window_3x3.sv - streaming 3x3 window generator over a raster pixel stream.
// Optional STRIDE2_EN: emit only windows whose top-left corner lies on even coordinates.
module conv_window_3x3
   import conv_window_pkg::*;
#(
   parameter int WID   = 8,
   parameter int IMG_W = 16,
   parameter int IMG_H = 16
) (
   input  logic                 CLK,
   input  logic                 SCLR,
   input  logic                 in_valid,
   input  logic [WID-1:0]       in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIN_N*WID-1:0] out_win,
   output logic                 frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   state_t               state;
   logic                 accept;
   logic                 last_col;
   logic                 last_row;
   logic                 last_pix;
   logic                 in_run;
   logic                 emit;
   logic [WID-1:0]       d0_out;
   logic [WID-1:0]       d1_out;
   logic [WID-1:0]       win     [WIN_K][WIN_K];
   logic [WID-1:0]       win_nxt [WIN_K][WIN_K];
   logic [WIN_N*WID-1:0] win_flat;

   assign in_ready = !out_valid || out_ready;
   // A pixel arriving alongside SCLR is discarded, so it must not shift anything either
   assign accept   = in_valid && in_ready && !SCLR;
   assign last_col = (col == CW'(IMG_W - 1));
   assign last_row = (row == RW'(IMG_H - 1));
   assign last_pix = last_col && last_row;
   assign in_run   = (row >= RW'(2)) && (col >= CW'(2));

`ifdef STRIDE2_EN
   assign emit = accept && in_run && !row[0] && !col[0];
`else
   assign emit = accept && in_run;
`endif

   line_delay #(.WID(WID), .DEPTH(IMG_W)) u_delay0 (
      .CLK  (CLK),
      .ce   (accept),
      .din  (in_data),
      .dout (d0_out)
   );

   line_delay #(.WID(WID), .DEPTH(IMG_W)) u_delay1 (
      .CLK  (CLK),
      .ce   (accept),
      .din  (d0_out),
      .dout (d1_out)
   );

   always_comb begin
      for (int r = 0; r < WIN_K; r++) begin
         win_nxt[r][0] = win[r][1];
         win_nxt[r][1] = win[r][2];
      end
      win_nxt[0][2] = d1_out;
      win_nxt[1][2] = d0_out;
      win_nxt[2][2] = in_data;
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < WIN_K; r++) begin
         for (int c = 0; c < WIN_K; c++) begin
            win_flat[WID*win_idx(r, c) +: WID] = win_nxt[r][c];
         end
      end
   end

   // Stale columns left over from the previous row are masked by the col>=2 emit gate
   always_ff @(posedge CLK) begin
      if (accept) begin
         win <= win_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (SCLR) begin
         out_valid  <= 1'b0;
         out_win    <= '0;
         frame_done <= 1'b0;
         col        <= '0;
         row        <= '0;
         state      <= IDLE;
      end else begin
         frame_done <= accept && last_pix;

         if (emit) begin
            out_valid <= 1'b1;
            out_win   <= win_flat;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         case (state)
            IDLE: if (accept) state <= FILL;
            FILL: begin
               if (accept && last_pix) state <= DONE;
               else if (accept && in_run) state <= RUN;
            end
            RUN:  if (accept && last_pix) state <= DONE;
            DONE: state <= accept ? FILL : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_3x3.sv
// tb/tb_conv_window_3x3.sv - scoreboard bench for conv_window_3x3 (6x6 frames, honours STRIDE2_EN)
module tb_conv_window_3x3;

   localparam int WID   = 8;
   localparam int IMG_W = 6;
   localparam int IMG_H = 6;
   localparam int WINW  = 9 * WID;
`ifdef STRIDE2_EN
   localparam int             EXP_WIN = ((IMG_W - 1) / 2) * ((IMG_H - 1) / 2);
   localparam logic [WID-1:0] LAST_TL = 8'd18;
   localparam logic [WID-1:0] LAST_BR = 8'd36;
`else
   localparam int             EXP_WIN = (IMG_W - 2) * (IMG_H - 2);
   localparam logic [WID-1:0] LAST_TL = 8'd27;
   localparam logic [WID-1:0] LAST_BR = 8'd45;
`endif

   logic            CLK = 1'b0;
   logic            SCLR = 1'b1;
   logic            in_valid = 1'b0;
   logic [WID-1:0]  in_data = '0;
   logic            out_ready = 1'b1;
   logic            in_ready;
   logic            out_valid;
   logic [WINW-1:0] out_win;
   logic            frame_done;

   conv_window_3x3 #(.WID(WID), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .CLK        (CLK),
      .SCLR       (SCLR),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_win    (out_win),
      .frame_done (frame_done)
   );

   always #5 CLK = ~CLK;

   int n_pass = 0;
   int n_total = 0;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_win(input string tag, input logic [WINW-1:0] obs, input logic [WINW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [WID-1:0] elem(input logic [WINW-1:0] w, input int r, input int c);
      return w[WID*(3*r+c) +: WID];
   endfunction

   // Reference model: the accepted frame is stored by position and windows are cut from it
   logic [WID-1:0]  pix [IMG_H][IMG_W];
   logic [WINW-1:0] exp_q [$];
   logic [WINW-1:0] rx_log [$];
   logic            exp_ov = 1'b0;
   logic            exp_fd = 1'b0;
   logic            hold_chk = 1'b0;
   logic [WINW-1:0] held = '0;
   int              mr = 0;
   int              mc = 0;
   int              win_cnt = 0;
   int              fd_cnt = 0;
   bit              mon_en = 1'b0;
   int              ready_mode = 0;
   int              cyc = 0;

   function automatic logic [WINW-1:0] model_win(input int r, input int c);
      logic [WINW-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[WID*(3*i+j) +: WID] = pix[r-2+i][c-2+j];
      return w;
   endfunction

   always @(posedge CLK) begin
      #1;
      cyc++;
      case (ready_mode)
         1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         2:       out_ready = 1'($urandom_range(1));
         default: out_ready = 1'b1;
      endcase
   end

   always @(negedge CLK) begin
      logic acc;
      logic em;
      logic [WINW-1:0] w;
      if (mon_en) begin
         check_bit("out_valid", out_valid, exp_ov);
         check_bit("frame_done", frame_done, exp_fd);
         check_bit("in_ready", in_ready, !exp_ov || out_ready);
         if (hold_chk) check_win("out_win_hold", out_win, held);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_int("unexpected_window", 1, 0);
            end else begin
               w = exp_q.pop_front();
               check_win("out_win", out_win, w);
            end
            rx_log.push_back(out_win);
            win_cnt++;
         end
         if (frame_done) fd_cnt++;
         hold_chk = out_valid && !out_ready;
         held     = out_win;

         acc = in_valid && (!exp_ov || out_ready);
         if (SCLR) begin
            exp_ov   = 1'b0;
            exp_fd   = 1'b0;
            hold_chk = 1'b0;
            mr       = 0;
            mc       = 0;
            exp_q.delete();
         end else begin
            em     = 1'b0;
            exp_fd = 1'b0;
            if (acc) begin
               pix[mr][mc] = in_data;
               em = (mr >= 2) && (mc >= 2);
`ifdef STRIDE2_EN
               em = em && (mr % 2 == 0) && (mc % 2 == 0);
`endif
               if (em) exp_q.push_back(model_win(mr, mc));
               exp_fd = (mr == IMG_H - 1) && (mc == IMG_W - 1);
               if (mc == IMG_W - 1) begin
                  mc = 0;
                  mr = (mr == IMG_H - 1) ? 0 : mr + 1;
               end else begin
                  mc = mc + 1;
               end
            end
            if (em) exp_ov = 1'b1;
            else if (out_ready) exp_ov = 1'b0;
         end
      end
   end

   task automatic send_frame(input int off, input int n, input int gap);
      bit got;
      for (int i = 0; i < n; i++) begin
         while (gap > 0 && $urandom_range(99) < gap) begin
            in_valid = 1'b0;
            @(posedge CLK); #1;
         end
         in_valid = 1'b1;
         in_data  = WID'(off + 8 * (i / IMG_W) + (i % IMG_W));
         got = 1'b0;
         for (int k = 0; k < 200 && !got; k++) begin
            @(negedge CLK);
            got = in_ready;
            @(posedge CLK); #1;
         end
         if (!got) begin
            check_int("accept_timeout", 0, 1);
            $fatal(1, "FAIL accept_timeout: pixel %0d never accepted", i);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      int bw;
      int bf;
      logic [WINW-1:0] w;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_frame_done", frame_done, 1'b0);
      check_bit("rst_in_ready", in_ready, 1'b1);
      check_win("rst_out_win", out_win, '0);
      @(posedge CLK); #1;
      SCLR   = 1'b0;
      mon_en = 1'b1;

      // continuous stream, consumer always ready
      bw = win_cnt; bf = fd_cnt;
      send_frame(0, IMG_W * IMG_H, 0);
      idle(10);
      check_int("t1_windows", win_cnt - bw, EXP_WIN);
      check_int("t1_frame_done", fd_cnt - bf, 1);
      check_int("t1_queue_empty", exp_q.size(), 0);
      if (rx_log.size() >= bw + EXP_WIN) begin
         w = rx_log[bw];
         check_int("t1_first_00", int'(elem(w, 0, 0)), 0);
         check_int("t1_first_02", int'(elem(w, 0, 2)), 2);
         check_int("t1_first_20", int'(elem(w, 2, 0)), 16);
         check_int("t1_first_22", int'(elem(w, 2, 2)), 18);
         w = rx_log[bw + EXP_WIN - 1];
         check_int("t1_last_00", int'(elem(w, 0, 0)), int'(LAST_TL));
         check_int("t1_last_22", int'(elem(w, 2, 2)), int'(LAST_BR));
      end else begin
         check_int("t1_log_size", rx_log.size() - bw, EXP_WIN);
      end

      // consumer stalls in a 1-0-0-1 pattern
      ready_mode = 1;
      bw = win_cnt; bf = fd_cnt;
      send_frame(0, IMG_W * IMG_H, 0);
      idle(10);
      check_int("t2_windows", win_cnt - bw, EXP_WIN);
      check_int("t2_frame_done", fd_cnt - bf, 1);
      check_int("t2_queue_empty", exp_q.size(), 0);

      // two frames back to back, second frame offset by 100
      ready_mode = 0;
      idle(2);
      bw = win_cnt; bf = fd_cnt;
      send_frame(0, IMG_W * IMG_H, 0);
      send_frame(100, IMG_W * IMG_H, 0);
      idle(10);
      check_int("t3_windows", win_cnt - bw, 2 * EXP_WIN);
      check_int("t3_frame_done", fd_cnt - bf, 2);
      check_int("t3_queue_empty", exp_q.size(), 0);
      if (rx_log.size() > bw + EXP_WIN) begin
         w = rx_log[bw + EXP_WIN];
         check_int("t3_f2_first_00", int'(elem(w, 0, 0)), 100);
         check_int("t3_f2_first_22", int'(elem(w, 2, 2)), 118);
      end else begin
         check_int("t3_log_size", rx_log.size() - bw, 2 * EXP_WIN);
      end

      // SCLR mid-frame, coinciding with an offered pixel, then a clean frame
      send_frame(0, 20, 0);
      in_valid = 1'b1;
      in_data  = 8'd99;
      SCLR     = 1'b1;
      @(posedge CLK); #1;
      SCLR     = 1'b0;
      in_valid = 1'b0;
      idle(3);
      bw = win_cnt; bf = fd_cnt;
      check_bit("t4_post_sclr_valid", out_valid, 1'b0);
      send_frame(0, IMG_W * IMG_H, 0);
      idle(10);
      check_int("t4_windows", win_cnt - bw, EXP_WIN);
      check_int("t4_frame_done", fd_cnt - bf, 1);
      check_int("t4_queue_empty", exp_q.size(), 0);

      // random input gaps and random consumer readiness
      ready_mode = 2;
      bw = win_cnt; bf = fd_cnt;
      send_frame(0, IMG_W * IMG_H, 50);
      ready_mode = 0;
      idle(10);
      check_int("t5_windows", win_cnt - bw, EXP_WIN);
      check_int("t5_frame_done", fd_cnt - bf, 1);
      check_int("t5_queue_empty", exp_q.size(), 0);
      if (rx_log.size() >= bw + EXP_WIN) begin
         w = rx_log[bw + EXP_WIN - 1];
         check_int("t5_last_00", int'(elem(w, 0, 0)), int'(LAST_TL));
         check_int("t5_last_22", int'(elem(w, 2, 2)), int'(LAST_BR));
      end else begin
         check_int("t5_log_size", rx_log.size() - bw, EXP_WIN);
      end

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
